dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder at the far end of the CPU's DM port. It holds a 32-word × 32-bit register-based store and answers the CPU's single-cycle loads and stores. A secondary debug/loader port with a valid/ready request and response handshake can read or write the same store whenever the CPU is not using it. It sits beside the CPU in the top level and is the only owner of data storage.

## Interface
- `DEPTH`, default 32: number of 32-bit words.
- `AW`, default 5: address width; `DEPTH == 2**AW`.
- `DW`, default 32: data width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable shared with the CPU; CPU-side writes are ignored when low.
- `DM_ena` in 1: CPU access strobe.
- `DM_worr` in 1: 1 = write, 0 = read.
- `DM_addr` in AW: word index.
- `DM_wdata` in DW: CPU store data.
- `DM_rdata` out DW: CPU load data (combinational).
- `dbg_req_valid` in 1: debug request valid.
- `dbg_req_ready` out 1: debug port can accept a request.
- `dbg_req_we` in 1: 1 = write, 0 = read.
- `dbg_req_addr` in AW: debug word index.
- `dbg_req_wdata` in DW: debug write data.
- `dbg_rsp_valid` out 1: response available.
- `dbg_rsp_ready` in 1: response consumed.
- `dbg_rsp_rdata` out DW: read data, or echoed write data for a write.
- `wr_count` out 16: committed-write counter, saturating.

## Operation
- **CPU read:** `DM_rdata = mem[DM_addr]` when `DM_ena && !DM_worr`, else 0. There is no latency, so the single-cycle CPU can issue a load every cycle.
- **CPU write:** `mem[DM_addr] <= DM_wdata` at the edge where `DM_ena && DM_worr && ena`.
- **CPU priority:** the CPU always wins. The debug port is blocked in any cycle with `DM_ena && ena`.
- **Debug FSM states:** IDLE, ACCESS, RESP.
- **IDLE:** `dbg_req_ready=1`. On `dbg_req_valid`, latch we/addr/wdata and go to ACCESS.
- **ACCESS:** `dbg_req_ready=0`.
  - If the CPU is blocking, hold in ACCESS. Each such cycle is one stall.
  - Otherwise perform the access. A write updates `mem` and loads `rsp_rdata` with the written data. A read loads `rsp_rdata` with `mem[addr]`. Then go to RESP.
- **RESP:** `dbg_rsp_valid=1` and `dbg_rsp_rdata` held stable. On `dbg_rsp_ready`, go to IDLE. There is no back-to-back acceptance in RESP.
- **wr_count:** increments by 1 for each committed write from either source. Only one source can commit per cycle. It saturates at 0xFFFF.
- **Reset (`rst` low, any time):**
  - All `mem` words = 0.
  - FSM = IDLE, `rsp_rdata` = 0, `wr_count` = 0.
  - An in-flight debug request is dropped with no response.
- **Reset values of outputs:**
  - `dbg_req_ready`=1, `dbg_rsp_valid`=0, `dbg_rsp_rdata`=0, `wr_count`=0.
  - `DM_rdata` = 0 while `DM_ena`=0.

## Timing
- **CPU read:** same-cycle combinational. A write at edge k is visible to a read in cycle k+1. A read in the same cycle as a write to the same address returns the old value.
- **Debug latency:** the request handshake at edge k puts the FSM in ACCESS. The access commits at edge k+1 if unblocked, and `dbg_rsp_valid` is high from edge k+1. Each blocked cycle adds one.
- **Request turnaround:** a request every 3 cycles at best (IDLE → ACCESS → RESP → IDLE).
- **Simultaneous access:** a CPU write and a debug access to the same address in the same cycle is impossible, because the debug access stalls. A debug read after a CPU write returns the CPU data.
- **ena low:** CPU writes are dropped, and the debug port is not blocked by `DM_ena`.

## Structure
- Shared package `dmem_pkg` holds:
  - `DEPTH`, `AW`, `DW` constants.
  - Debug state enum `dbg_state_t {IDLE, ACCESS, RESP}`.
  - `WR_COUNT_MAX` = 16'hFFFF.
- One natural sub-module, `dmem_array`, contains:
  - The register array with async active-low clear.
  - One write port, with the write-select mux in the parent.
  - Two combinational read ports (CPU, debug).
- The FSM, arbitration and counter live in `dmem_responder`.

## Test plan
- **Reset:** with `rst`=0, then release → `dbg_req_ready`=1, `dbg_rsp_valid`=0, `wr_count`=0, and a CPU read of addr 7 returns 0.
- **CPU store/load:** CPU write 0xDEADBEEF to addr 3, then read addr 3 next cycle → `DM_rdata`=0xDEADBEEF and `wr_count`=1. Repeat the write with `ena`=0 → memory unchanged and `wr_count` stays 1.
- **Debug write then CPU read:** debug write 0x12345678 to addr 31 with the CPU idle → `dbg_rsp_valid` one cycle after acceptance and `dbg_rsp_rdata`=0x12345678. A CPU read of addr 31 then returns 0x12345678.
- **Conflict stall:** debug read of addr 3 accepted while the CPU asserts `DM_ena` for 4 cycles, writing 0xA5A5A5A5 to addr 3 → FSM holds ACCESS for 4 cycles. `dbg_rsp_rdata` then returns 0xA5A5A5A5.
- **Response backpressure:** hold `dbg_rsp_ready`=0 for 5 cycles in RESP → `dbg_rsp_valid` and `dbg_rsp_rdata` stay stable and `dbg_req_ready`=0. Raising `dbg_rsp_ready` returns the FSM to IDLE next cycle.
- **Saturation and mid-op reset:**
  - Preload `wr_count` near 0xFFFF via 0xFFFF writes, then one more write → `wr_count` stays 0xFFFF.
  - Assert `rst` while in ACCESS → no response is issued and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and debug FSM states for the data-memory responder
package dmem_pkg;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} dbg_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: register store with one write port and two combinational read ports
module dmem_array #(
    parameter int DEPTH = dmem_pkg::DEPTH,
    parameter int AW = dmem_pkg::AW,
    parameter int DW = dmem_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst)
        if (!rst) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data memory with a debug/loader port that stalls behind CPU traffic
module dmem_responder #(
    parameter int DEPTH = dmem_pkg::DEPTH,
    parameter int AW = dmem_pkg::AW,
    parameter int DW = dmem_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          DM_ena,
    input  logic          DM_worr,
    input  logic [AW-1:0] DM_addr,
    input  logic [DW-1:0] DM_wdata,
    output logic [DW-1:0] DM_rdata,
    input  logic          dbg_req_valid,
    output logic          dbg_req_ready,
    input  logic          dbg_req_we,
    input  logic [AW-1:0] dbg_req_addr,
    input  logic [DW-1:0] dbg_req_wdata,
    output logic          dbg_rsp_valid,
    input  logic          dbg_rsp_ready,
    output logic [DW-1:0] dbg_rsp_rdata,
    output logic [15:0]   wr_count
);
    import dmem_pkg::*;

    dbg_state_t state, state_n;
    logic q_we;
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_wdata, cpu_rd, dbg_rd;
    logic cpu_blk, cpu_we, dbg_go, mem_we;

    assign cpu_blk = DM_ena && ena;
    assign cpu_we = cpu_blk && DM_worr;
    assign dbg_go = state == ACCESS && !cpu_blk;
    assign mem_we = cpu_we || (dbg_go && q_we);
    assign DM_rdata = (DM_ena && !DM_worr) ? cpu_rd : '0;

    dmem_array #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_array (
        .clk(clk),
        .rst(rst),
        .we(mem_we),
        .waddr(cpu_we ? DM_addr : q_addr),
        .wdata(cpu_we ? DM_wdata : q_wdata),
        .raddr_a(DM_addr),
        .rdata_a(cpu_rd),
        .raddr_b(q_addr),
        .rdata_b(dbg_rd)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        dbg_req_ready = state == IDLE;
        dbg_rsp_valid = state == RESP;
        unique case (state)
            IDLE:    state_n = dbg_req_valid ? ACCESS : IDLE;
            ACCESS:  state_n = cpu_blk ? ACCESS : RESP;
            RESP:    state_n = dbg_rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            q_we <= 1'b0;
            q_addr <= '0;
            q_wdata <= '0;
            dbg_rsp_rdata <= '0;
            wr_count <= '0;
        end else begin
            if (state == IDLE && dbg_req_valid) begin
                q_we <= dbg_req_we;
                q_addr <= dbg_req_addr;
                q_wdata <= dbg_req_wdata;
            end
            if (dbg_go) dbg_rsp_rdata <= q_we ? q_wdata : dbg_rd;
            if (mem_we && wr_count != WR_COUNT_MAX) wr_count <= wr_count + 16'd1;
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks against a transaction-level memory model
module tb_dmem_responder;
    logic clk = 0, rst = 0, ena = 1;
    logic DM_ena = 0, DM_worr = 0;
    logic [4:0] DM_addr = 0;
    logic [31:0] DM_wdata = 0, DM_rdata;
    logic dbg_req_valid = 0, dbg_req_ready, dbg_req_we = 0;
    logic [4:0] dbg_req_addr = 0;
    logic [31:0] dbg_req_wdata = 0, dbg_rsp_rdata;
    logic dbg_rsp_valid, dbg_rsp_ready = 0;
    logic [15:0] wr_count;

    logic [31:0] ref_mem [32];
    int ref_cnt = 0;
    int vectors = 0, errs = 0;

    dmem_responder dut (
        .clk(clk), .rst(rst), .ena(ena),
        .DM_ena(DM_ena), .DM_worr(DM_worr), .DM_addr(DM_addr),
        .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
        .wr_count(wr_count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void note_write(input logic [4:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        if (ref_cnt < 65535) ref_cnt++;
    endfunction

    task automatic cpu_write(input logic [4:0] a, input logic [31:0] d, input logic e);
        ena = e; DM_ena = 1; DM_worr = 1; DM_addr = a; DM_wdata = d;
        tick;
        if (e) note_write(a, d);
        DM_ena = 0; DM_worr = 0; ena = 1;
    endtask

    task automatic cpu_read(input logic [4:0] a);
        DM_ena = 1; DM_worr = 0; DM_addr = a;
        #2;
        chk("cpu_rdata", DM_rdata, ref_mem[a]);
        chk("wr_count", 32'(wr_count), 32'(ref_cnt));
        DM_ena = 0;
        tick;
    endtask

    task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input int nstall, input logic [4:0] sa, input logic [31:0] sd, input int nbp);
        logic [31:0] exp;
        dbg_req_valid = 1; dbg_req_we = we; dbg_req_addr = a; dbg_req_wdata = d;
        #1;
        chk("req_ready_idle", 32'(dbg_req_ready), 1);
        tick;
        dbg_req_valid = 0;
        for (int i = 0; i < nstall; i++) begin
            DM_ena = 1; DM_worr = 1; DM_addr = sa; DM_wdata = sd;
            #1;
            chk("stall_rsp_valid", 32'(dbg_rsp_valid), 0);
            chk("stall_req_ready", 32'(dbg_req_ready), 0);
            tick;
            note_write(sa, sd);
        end
        DM_ena = 0; DM_worr = 0;
        exp = we ? d : ref_mem[a];
        tick;
        if (we) note_write(a, d);
        chk("rsp_valid", 32'(dbg_rsp_valid), 1);
        chk("rsp_rdata", dbg_rsp_rdata, exp);
        for (int i = 0; i < nbp; i++) begin
            tick;
            chk("bp_rsp_valid", 32'(dbg_rsp_valid), 1);
            chk("bp_rsp_rdata", dbg_rsp_rdata, exp);
            chk("bp_req_ready", 32'(dbg_req_ready), 0);
        end
        dbg_rsp_ready = 1;
        tick;
        dbg_rsp_ready = 0;
        chk("done_req_ready", 32'(dbg_req_ready), 1);
        chk("done_rsp_valid", 32'(dbg_rsp_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 0;
        DM_ena = 1; DM_addr = 7;
        #2;
        chk("rst_req_ready", 32'(dbg_req_ready), 1);
        chk("rst_rsp_valid", 32'(dbg_rsp_valid), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_read7", DM_rdata, 0);
        DM_ena = 0;
        tick;
        tick;
        rst = 1;
        tick;
        cpu_read(7);

        cpu_write(3, 32'hDEADBEEF, 1);
        cpu_read(3);
        cpu_write(3, 32'h0BADF00D, 0);
        cpu_read(3);

        dbg_txn(1, 31, 32'h12345678, 0, 0, 0, 0);
        cpu_read(31);

        dbg_txn(0, 3, 0, 4, 3, 32'hA5A5A5A5, 0);
        chk("conflict_rdata", dbg_rsp_rdata, 32'hA5A5A5A5);

        dbg_txn(0, 31, 0, 0, 0, 0, 5);

        dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 3;
        tick;
        dbg_req_valid = 0; ena = 0; DM_ena = 1; DM_worr = 1; DM_addr = 9; DM_wdata = 32'h55;
        tick;
        chk("ena_low_no_block", 32'(dbg_rsp_valid), 1);
        chk("ena_low_rdata", dbg_rsp_rdata, ref_mem[3]);
        DM_ena = 0; DM_worr = 0; ena = 1; dbg_rsp_ready = 1;
        tick;
        dbg_rsp_ready = 0;
        cpu_read(9);

        repeat (150) begin
            case ($urandom_range(0, 2))
                0: cpu_write(5'($urandom), $urandom, 1'($urandom));
                1: cpu_read(5'($urandom));
                default: dbg_txn(1'($urandom), 5'($urandom), $urandom,
                                 $urandom_range(0, 3), 5'($urandom), $urandom, $urandom_range(0, 3));
            endcase
        end
        for (int i = 0; i < 32; i++) cpu_read(5'(i));

        DM_ena = 1; DM_worr = 1;
        while (ref_cnt < 65535) begin
            DM_addr = 5'($urandom); DM_wdata = $urandom;
            tick;
            note_write(DM_addr, DM_wdata);
        end
        DM_ena = 0; DM_worr = 0;
        #1;
        chk("sat_reach", 32'(wr_count), 32'hFFFF);
        cpu_write(1, 32'h1, 1);
        dbg_txn(1, 2, 32'h2, 0, 0, 0, 0);
        cpu_read(1);
        chk("sat_hold", 32'(wr_count), 32'hFFFF);

        dbg_req_valid = 1; dbg_req_we = 1; dbg_req_addr = 4; dbg_req_wdata = 32'hCAFEF00D;
        tick;
        dbg_req_valid = 0; DM_ena = 1; DM_worr = 0; DM_addr = 31;
        #1;
        rst = 0;
        #1;
        chk("mid_rst_req_ready", 32'(dbg_req_ready), 1);
        chk("mid_rst_rsp_valid", 32'(dbg_rsp_valid), 0);
        chk("mid_rst_rsp_rdata", dbg_rsp_rdata, 0);
        chk("mid_rst_wr_count", 32'(wr_count), 0);
        chk("mid_rst_read31", DM_rdata, 0);
        DM_ena = 0;
        tick;
        rst = 1;
        for (int i = 0; i < 32; i++) ref_mem[i] = 0;
        ref_cnt = 0;
        repeat (3) begin
            tick;
            chk("post_rst_no_rsp", 32'(dbg_rsp_valid), 0);
        end
        cpu_read(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
